// File: rtl/pdm_demod.sv
// PDM-to-PCM demodulator: counts ones over a 2^DECIM_LOG2-sample window, scales
// and saturates the count, then smooths it with a 2^AVG_LOG2-window moving average.
module pdm_demod #(
   parameter int unsigned WIDTH      = 10,
   parameter int unsigned DECIM_LOG2 = 10,
   parameter int unsigned AVG_LOG2   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             din,
   output logic [WIDTH-1:0] dout,
   output logic             valid
);

   localparam int unsigned M    = 1 << AVG_LOG2;
   localparam int unsigned SUMW = WIDTH + AVG_LOG2;
   localparam int unsigned PW   = AVG_LOG2 + 1;
   localparam int unsigned SCW  = ((DECIM_LOG2 >= WIDTH) ? DECIM_LOG2 : WIDTH) + 1;
   localparam int unsigned SHR  = (DECIM_LOG2 >= WIDTH) ? (DECIM_LOG2 - WIDTH) : 0;
   localparam int unsigned SHL  = (DECIM_LOG2 >= WIDTH) ? 0 : (WIDTH - DECIM_LOG2);

   logic [DECIM_LOG2-1:0] wcnt;
   logic [DECIM_LOG2:0]   acc;
   logic [WIDTH-1:0]      raw_q;
   logic                  raw_stb;
   logic [WIDTH-1:0]      hist [M];
   logic [SUMW-1:0]       sum;
   logic                  primed;
   logic [PW-1:0]         pcnt;

   logic [DECIM_LOG2:0]   raw_c;
   logic [SCW-1:0]        scaled_c;
   logic [WIDTH-1:0]      sat_c;
   logic [SUMW-1:0]       sum_next_c;

   // Window total, rescale to WIDTH bits and clamp the all-ones case (N -> 2^WIDTH).
   always_comb begin
      raw_c      = acc + (DECIM_LOG2 + 1)'(din);
      scaled_c   = (SCW'(raw_c) >> SHR) << SHL;
      sat_c      = (|scaled_c[SCW-1:WIDTH]) ? '1 : scaled_c[WIDTH-1:0];
      sum_next_c = sum + SUMW'(raw_q) - SUMW'(hist[M-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt    <= '0;
         acc     <= '0;
         raw_q   <= '0;
         raw_stb <= 1'b0;
         for (int i = 0; i < int'(M); i++) hist[i] <= '0;
         sum     <= '0;
         primed  <= 1'b0;
         pcnt    <= '0;
         dout    <= '0;
         valid   <= 1'b0;
      end else begin
         raw_stb <= 1'b0;
         valid   <= 1'b0;

         // Stage 1: decimation window
         if (en) begin
            wcnt <= wcnt + 1'b1;
            if (&wcnt) begin
               acc     <= '0;
               raw_q   <= sat_c;
               raw_stb <= 1'b1;
            end else begin
               acc <= raw_c;
            end
         end

         // Stage 2: moving average; history keeps filling while unprimed
         if (raw_stb) begin
            hist[0] <= raw_q;
            for (int i = 1; i < int'(M); i++) hist[i] <= hist[i-1];
            sum <= sum_next_c;
            if (primed || (pcnt == PW'(M - 1))) begin
               primed <= 1'b1;
               valid  <= 1'b1;
               dout   <= WIDTH'(sum_next_c >> AVG_LOG2);
            end else begin
               pcnt <= pcnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pdm_demod.sv
// Randomized scoreboard bench for pdm_demod: a window/average reference model
// queues expected outputs, a negedge monitor checks every cycle against it.
module tb_pdm_demod;

   localparam int unsigned WIDTH = 10;
   localparam int unsigned DL    = 10;
   localparam int unsigned AL    = 2;
   localparam int unsigned N     = 1 << DL;
   localparam int unsigned M     = 1 << AL;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             din;
   logic [WIDTH-1:0] dout;
   logic             valid;

   always #5 clk = ~clk;

   pdm_demod #(.WIDTH(WIDTH), .DECIM_LOG2(DL), .AVG_LOG2(AL)) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .din   (din),
      .dout  (dout),
      .valid (valid)
   );

   typedef struct {
      int unsigned cyc;
      bit          v;
      bit          is_rst;
      int unsigned val;
   } exp_t;

   exp_t        sbq[$];
   int unsigned ecnt = 0;
   int          tests = 0;
   int          fails = 0;

   int unsigned m_cnt, m_ones, m_wins;
   int unsigned m_hist[$];
   int unsigned hold = 0;

   task automatic check(input string name, input bit ok, input longint act, input longint expv);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", name, ecnt, act, expv);
      end
   endtask

   // Reference model: count ones per N enabled samples, scale, clamp, average last M.
   always @(posedge clk) begin
      ecnt++;
      if (rst) begin
         sbq.delete();
         m_cnt  = 0;
         m_ones = 0;
         m_wins = 0;
         m_hist = {};
         for (int i = 0; i < int'(M); i++) m_hist.push_back(0);
         sbq.push_back('{cyc: ecnt, v: 1'b0, is_rst: 1'b1, val: 0});
      end else if (en) begin
         m_ones += (din === 1'b1) ? 1 : 0;
         m_cnt++;
         if (m_cnt == N) begin
            longint      level;
            longint      total;
            level = (longint'(m_ones) * (longint'(1) << WIDTH)) / N;
            if (level > (longint'(1) << WIDTH) - 1) level = (longint'(1) << WIDTH) - 1;
            m_hist.push_back(int'(level));
            void'(m_hist.pop_front());
            m_wins++;
            total = 0;
            foreach (m_hist[i]) total += m_hist[i];
            sbq.push_back('{cyc: ecnt + 1, v: (m_wins >= M), is_rst: 1'b0,
                            val: int'(total / M)});
            m_cnt  = 0;
            m_ones = 0;
         end
      end
   end

   // Monitor: every cycle either matches a queued completion or must be idle/holding.
   always @(negedge clk) begin
      if (sbq.size() > 0 && sbq[0].cyc == ecnt) begin
         exp_t e;
         e = sbq.pop_front();
         if (e.is_rst) begin
            check("reset_valid", valid === 1'b0, longint'(valid), 0);
            check("reset_dout", dout === '0, longint'(dout), 0);
            hold = 0;
         end else if (e.v) begin
            check("valid_pulse", valid === 1'b1, longint'(valid), 1);
            check("dout_value", dout === WIDTH'(e.val), longint'(dout), longint'(e.val));
            hold = e.val;
         end else begin
            check("priming_no_valid", valid === 1'b0, longint'(valid), 0);
            check("priming_dout_hold", dout === WIDTH'(hold), longint'(dout), longint'(hold));
         end
      end else begin
         check("spurious_valid", valid === 1'b0, longint'(valid), 0);
         check("dout_hold", dout === WIDTH'(hold), longint'(dout), longint'(hold));
      end
   end

   // mode 0: constant din; 1: alternating 1,0; 2: en every other cycle, din=1 when
   // enabled and random when not; 3: random en (~3/4) and random din.
   task automatic drive(input int unsigned n_en, input int mode, input bit val);
      int unsigned k = 0;
      int unsigned c = 0;
      while (k < n_en) begin
         case (mode)
            0: begin en = 1'b1; din = val; end
            1: begin en = 1'b1; din = (k % 2 == 0); end
            2: begin en = (c % 2 == 0); din = en ? 1'b1 : 1'($urandom); end
            default: begin en = (($urandom % 4) != 0); din = 1'($urandom); end
         endcase
         if (en) k++;
         c++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      din = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;

      drive(5 * N, 0, 1'b1);   // all ones: priming then full scale
      drive(5 * N, 0, 1'b0);   // all zeros, with ramp-down through the average
      drive(5 * N, 0, 1'b1);   // ramp up 255/511/767/1023 from a window boundary
      drive(5 * N, 1, 1'b0);   // half density
      drive(5 * N, 2, 1'b0);   // en every other cycle
      drive(6 * N, 3, 1'b0);   // random en/din

      drive(5 * N + 500, 3, 1'b0);
      rst = 1'b1;              // mid-window reset with en active
      en  = 1'b1;
      din = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(6 * N, 3, 1'b0);

      en  = 1'b0;
      din = 1'b0;
      repeat (6) begin
         @(posedge clk);
         #1;
      end
      check("scoreboard_drained", sbq.size() == 0, longint'(sbq.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
